// File: rtl/piso_serializer.sv
// Parallel-in serial-out feeder: takes a word over valid/ready, appends an
// optional even-parity bit and shifts the frame out one bit per clock.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(WIDTH - 1);

  generate
    if (WIDTH < 2) begin : g_bad_width
      $error("piso_serializer: WIDTH must be at least 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             par_q, par_d;
  logic             sout_q, sout_d;
  logic             vld_q, vld_d;
  logic             busy_q, busy_d;

  logic             data_end;
  logic             last_bit;
  logic             ready;
  logic             accept;

  // Bit that goes on the line next, taken from the transmit end of the word.
  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    logic [WIDTH-1:0] r;
    if (MSB_FIRST) r = {w[WIDTH-2:0], 1'b0};
    else           r = {1'b0, w[WIDTH-1:1]};
    return r;
  endfunction

  always_comb begin
    data_end = (state_q == SHIFT) && (cnt_q == LAST_DATA);
    last_bit = PARITY_EN ? (state_q == PARITY) : data_end;
    ready    = (state_q == IDLE) || last_bit;
    accept   = din_valid && ready;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      sout_q  <= 1'b0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      sout_q  <= sout_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = SHIFT;
      end
      SHIFT: begin
        if (data_end) begin
          if (PARITY_EN)   state_d = PARITY;
          else if (accept) state_d = SHIFT;
          else             state_d = IDLE;
        end
      end
      PARITY: begin
        state_d = accept ? SHIFT : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A frame end without a new accept returns the line to an all-zero idle.
  always_comb begin
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    sout_d  = sout_q;
    vld_d   = vld_q;
    busy_d  = busy_q;
    if (accept) begin
      cnt_d   = '0;
      shreg_d = advance(din);
      par_d   = ^din;
      sout_d  = head_bit(din);
      vld_d   = 1'b1;
      busy_d  = 1'b1;
    end else if (last_bit) begin
      cnt_d   = '0;
      shreg_d = '0;
      par_d   = 1'b0;
      sout_d  = 1'b0;
      vld_d   = 1'b0;
      busy_d  = 1'b0;
    end else if (state_q == SHIFT) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (data_end) begin
        sout_d = par_q;
      end else begin
        sout_d  = head_bit(shreg_q);
        shreg_d = advance(shreg_q);
      end
    end
  end

  always_comb begin
    din_ready  = ready;
    done       = last_bit;
    sout       = sout_q;
    sout_valid = vld_q;
    busy       = busy_q;
  end

  a_done_in_frame : assert property (@(posedge clk) disable iff (!rst) done |-> sout_valid);
  a_busy_tracks   : assert property (@(posedge clk) disable iff (!rst) busy == sout_valid);

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: one MSB-first and one LSB-first instance,
// each cycle compares {sout, sout_valid, busy, done, din_ready} to hand values.
module tb_piso_serializer;

  logic       clk;
  logic       rst;
  logic [7:0] din_m, din_l;
  logic       vld_m, vld_l;
  logic       rdy_m, rdy_l;
  logic       sout_m, sout_l;
  logic       sv_m, sv_l;
  logic       busy_m, busy_l;
  logic       done_m, done_l;

  int n_vec  = 0;
  int n_fail = 0;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .PARITY_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .din(din_m), .din_valid(vld_m), .din_ready(rdy_m),
    .sout(sout_m), .sout_valid(sv_m), .busy(busy_m), .done(done_m)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .PARITY_EN(1'b1)) dut_lsb (
    .clk(clk), .rst(rst), .din(din_l), .din_valid(vld_l), .din_ready(rdy_l),
    .sout(sout_l), .sout_valid(sv_l), .busy(busy_l), .done(done_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [4:0] obs, exp;
    rst = 1'b0;
    din_m = 8'hFF; vld_m = 1'b1;
    din_l = 8'hFF; vld_l = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      exp = 5'b00001;
      obs = {sout_m, sv_m, busy_m, done_m, rdy_m};
      n_vec++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL reset_msb cyc%0d: got %b want %b", i, obs, exp);
      end
      obs = {sout_l, sv_l, busy_l, done_l, rdy_l};
      n_vec++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL reset_lsb cyc%0d: got %b want %b", i, obs, exp);
      end
    end
    vld_m = 1'b0; vld_l = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      exp = 5'b00001;
      obs = {sout_m, sv_m, busy_m, done_m, rdy_m};
      n_vec++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL post_reset_idle cyc%0d: got %b want %b", i, obs, exp);
      end
    end
  endtask

  task automatic test_msb_frame();
    logic [8:0] seq;
    logic [4:0] obs, exp;
    seq = 9'b101001010;
    din_m = 8'hA5; vld_m = 1'b1;
    step();
    vld_m = 1'b0; din_m = 8'h00;
    for (int i = 1; i <= 9; i++) begin
      exp = {seq[9-i], 1'b1, 1'b1, (i == 9), (i == 9)};
      obs = {sout_m, sv_m, busy_m, done_m, rdy_m};
      n_vec++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL msb_a5 cyc%0d: got %b want %b", i, obs, exp);
      end
      step();
    end
    exp = 5'b00001;
    obs = {sout_m, sv_m, busy_m, done_m, rdy_m};
    n_vec++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL msb_a5 end: got %b want %b", obs, exp);
    end
  endtask

  task automatic test_lsb_odd();
    logic [8:0] seq;
    logic [4:0] obs, exp;
    seq = 9'b100000001;
    din_l = 8'h01; vld_l = 1'b1;
    step();
    vld_l = 1'b0; din_l = 8'hFF;
    for (int i = 1; i <= 9; i++) begin
      exp = {seq[9-i], 1'b1, 1'b1, (i == 9), (i == 9)};
      obs = {sout_l, sv_l, busy_l, done_l, rdy_l};
      n_vec++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL lsb_01 cyc%0d: got %b want %b", i, obs, exp);
      end
      step();
    end
    exp = 5'b00001;
    obs = {sout_l, sv_l, busy_l, done_l, rdy_l};
    n_vec++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL lsb_01 end: got %b want %b", obs, exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [17:0] seq;
    logic [4:0]  obs, exp;
    logic        lastc;
    seq = 18'b111111110_000000000;
    din_m = 8'hFF; vld_m = 1'b1;
    step();
    for (int i = 1; i <= 18; i++) begin
      lastc = (i == 9) || (i == 18);
      exp = {seq[18-i], 1'b1, 1'b1, lastc, lastc};
      obs = {sout_m, sv_m, busy_m, done_m, rdy_m};
      n_vec++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL b2b cyc%0d: got %b want %b", i, obs, exp);
      end
      if (i == 9)  din_m = 8'h00;
      if (i == 10) vld_m = 1'b0;
      step();
    end
    exp = 5'b00001;
    obs = {sout_m, sv_m, busy_m, done_m, rdy_m};
    n_vec++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL b2b end: got %b want %b", obs, exp);
    end
  endtask

  task automatic test_busy_ignore();
    logic [8:0] seq;
    logic [4:0] obs, exp;
    seq = 9'b101001010;
    din_m = 8'hA5; vld_m = 1'b1;
    step();
    vld_m = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      exp = {seq[9-i], 1'b1, 1'b1, (i == 9), (i == 9)};
      obs = {sout_m, sv_m, busy_m, done_m, rdy_m};
      n_vec++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL busy_ignore cyc%0d: got %b want %b", i, obs, exp);
      end
      if (i == 3) begin
        din_m = 8'h3C; vld_m = 1'b1;
      end else begin
        vld_m = 1'b0;
      end
      step();
    end
    for (int i = 0; i < 3; i++) begin
      exp = 5'b00001;
      obs = {sout_m, sv_m, busy_m, done_m, rdy_m};
      n_vec++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL busy_ignore idle%0d: got %b want %b", i, obs, exp);
      end
      step();
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [8:0] seq;
    logic [4:0] obs, exp;
    seq = 9'b101001010;
    din_m = 8'hA5; vld_m = 1'b1;
    step();
    vld_m = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      exp = {seq[9-i], 1'b1, 1'b1, 1'b0, 1'b0};
      obs = {sout_m, sv_m, busy_m, done_m, rdy_m};
      n_vec++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL rst_mid pre cyc%0d: got %b want %b", i, obs, exp);
      end
      if (i < 4) step();
    end
    #2;
    rst = 1'b0;
    #1;
    exp = 5'b00001;
    obs = {sout_m, sv_m, busy_m, done_m, rdy_m};
    n_vec++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL rst_mid async: got %b want %b", obs, exp);
    end
    step();
    obs = {sout_m, sv_m, busy_m, done_m, rdy_m};
    n_vec++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL rst_mid held: got %b want %b", obs, exp);
    end
    rst = 1'b1;
    step();
    obs = {sout_m, sv_m, busy_m, done_m, rdy_m};
    n_vec++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL rst_mid released: got %b want %b", obs, exp);
    end
    seq = 9'b000011110;
    din_m = 8'h0F; vld_m = 1'b1;
    step();
    vld_m = 1'b0; din_m = 8'hF0;
    for (int i = 1; i <= 9; i++) begin
      exp = {seq[9-i], 1'b1, 1'b1, (i == 9), (i == 9)};
      obs = {sout_m, sv_m, busy_m, done_m, rdy_m};
      n_vec++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL rst_mid 0f cyc%0d: got %b want %b", i, obs, exp);
      end
      step();
    end
    exp = 5'b00001;
    obs = {sout_m, sv_m, busy_m, done_m, rdy_m};
    n_vec++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL rst_mid 0f end: got %b want %b", obs, exp);
    end
  endtask

  initial begin
    rst   = 1'b0;
    din_m = 8'h00; vld_m = 1'b0;
    din_l = 8'h00; vld_l = 1'b0;
    test_reset();
    test_msb_frame();
    test_lsb_odd();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
